// File: rtl/intersection_pkg.sv
// Shared state and signal-head encodings for the intersection controller.
package intersection_pkg;

    typedef enum logic [2:0] {
        ALL_RED   = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        PED_WALK  = 3'd5
    } state_t;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    localparam logic ROAD_NS = 1'b0;
    localparam logic ROAD_EW = 1'b1;

    function automatic logic [2:0] ns_head(input state_t s);
        case (s)
            NS_GREEN:  ns_head = LIGHT_GREEN;
            NS_YELLOW: ns_head = LIGHT_YELLOW;
            default:   ns_head = LIGHT_RED;
        endcase
    endfunction

    function automatic logic [2:0] ew_head(input state_t s);
        case (s)
            EW_GREEN:  ew_head = LIGHT_GREEN;
            EW_YELLOW: ew_head = LIGHT_YELLOW;
            default:   ew_head = LIGHT_RED;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: clears on phase entry, saturates at SAT, flags count >= cmp.
module phase_timer #(
    parameter int W   = 3,
    parameter int SAT = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] cmp,
    output logic         hit
);

    logic [W-1:0] count_r;

    // Counter register with clear and saturation
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (count_r != W'(SAT)) begin
            count_r <= count_r + W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign hit = (count_r >= cmp);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road traffic light controller with optional pedestrian walk phase.
// Pedestrian phase is built only when INTERSECTION_PED_WALK_EN is defined.
module intersection_ctrl
    import intersection_pkg::*;
#(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 8,
    parameter int YELLOW_T  = 2,
    parameter int ALL_RED_T = 1,
    parameter int WALK_T    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_ns,
    input  logic       req_ew,
    input  logic       ped_req,
    output logic [2:0] light_ns,
    output logic [2:0] light_ew,
    output logic       walk
);

    localparam int CW = (GREEN_MAX > 1) ? $clog2(GREEN_MAX) : 1;

    state_t        state_r;
    state_t        next_state_s;
    logic          next_road_r;
    logic          from_walk_r;
    logic          ped_pending_s;
    logic          leave_s;
    logic          hit_s;
    logic [CW-1:0] cmp_s;
    logic [2:0]    light_ns_r;
    logic [2:0]    light_ew_r;
    logic          walk_r;

`ifdef INTERSECTION_PED_WALK_EN
    logic ped_pending_r;

    // Latch button presses until the walk phase is entered
    always_ff @(posedge clk) begin
        if (rst) begin
            ped_pending_r <= 1'b0;
        end else if (state_r == ALL_RED && next_state_s == PED_WALK) begin
            ped_pending_r <= 1'b0;
        end else if (ped_req) begin
            ped_pending_r <= 1'b1;
        end else begin
            ped_pending_r <= ped_pending_r;
        end
    end

    assign ped_pending_s = ped_pending_r;
`else
    logic unused_ped_s;
    assign unused_ped_s  = ped_req;
    assign ped_pending_s = 1'b0;
`endif

    // Select the duration threshold of the current phase
    always_comb begin
        cmp_s = CW'(ALL_RED_T - 1);
        case (state_r)
            ALL_RED:              cmp_s = CW'(ALL_RED_T - 1);
            NS_GREEN, EW_GREEN:   cmp_s = CW'(GREEN_MIN - 1);
            NS_YELLOW, EW_YELLOW: cmp_s = CW'(YELLOW_T - 1);
            PED_WALK:             cmp_s = CW'(WALK_T - 1);
            default:              cmp_s = CW'(ALL_RED_T - 1);
        endcase
    end

    phase_timer #(
        .W   (CW),
        .SAT (GREEN_MAX - 1)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (leave_s),
        .cmp (cmp_s),
        .hit (hit_s)
    );

    // Next-state decision; greens leave only once min time is met and demand competes
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ALL_RED: begin
                if (!hit_s) begin
                    next_state_s = ALL_RED;
                end else if (ped_pending_s && !from_walk_r) begin
                    next_state_s = PED_WALK;
                end else if (next_road_r == ROAD_EW) begin
                    next_state_s = EW_GREEN;
                end else begin
                    next_state_s = NS_GREEN;
                end
            end
            NS_GREEN: begin
                if (hit_s && (req_ew || ped_pending_s)) begin
                    next_state_s = NS_YELLOW;
                end else begin
                    next_state_s = NS_GREEN;
                end
            end
            EW_GREEN: begin
                if (hit_s && (req_ns || ped_pending_s)) begin
                    next_state_s = EW_YELLOW;
                end else begin
                    next_state_s = EW_GREEN;
                end
            end
            NS_YELLOW, EW_YELLOW, PED_WALK: begin
                if (hit_s) begin
                    next_state_s = ALL_RED;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: next_state_s = ALL_RED;
        endcase
    end

    assign leave_s = (next_state_s != state_r);

    // State, road alternation and registered signal heads
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ALL_RED;
            next_road_r <= ROAD_NS;
            from_walk_r <= 1'b0;
            light_ns_r  <= LIGHT_RED;
            light_ew_r  <= LIGHT_RED;
            walk_r      <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            light_ns_r <= ns_head(next_state_s);
            light_ew_r <= ew_head(next_state_s);
`ifdef INTERSECTION_PED_WALK_EN
            walk_r     <= (next_state_s == PED_WALK);
`else
            walk_r     <= 1'b0;
`endif
            if ((state_r == NS_YELLOW || state_r == EW_YELLOW) && leave_s) begin
                next_road_r <= ~next_road_r;
            end else begin
                next_road_r <= next_road_r;
            end
            // The clearance after a walk must hand over to a green, not re-enter walk
            if (leave_s) begin
                from_walk_r <= (state_r == PED_WALK);
            end else begin
                from_walk_r <= from_walk_r;
            end
        end
    end

    assign light_ns = light_ns_r;
    assign light_ew = light_ew_r;
    assign walk     = walk_r;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Self-checking bench for intersection_ctrl against a phase/duration reference model.
module tb_intersection_ctrl;

    localparam int GREEN_MIN = 4;
    localparam int GREEN_MAX = 8;
    localparam int YELLOW_T  = 2;
    localparam int ALL_RED_T = 1;
    localparam int WALK_T    = 3;

    localparam int P_RED    = 0;
    localparam int P_GREEN  = 1;
    localparam int P_YELLOW = 2;
    localparam int P_WALK   = 3;

`ifdef INTERSECTION_PED_WALK_EN
    localparam int EXP_WALKS = WALK_T;
`else
    localparam int EXP_WALKS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_ns = 1'b0;
    logic       req_ew = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] light_ns;
    logic [2:0] light_ew;
    logic       walk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: phase kind, road served, cycles elapsed in phase
    int m_phase = P_RED;
    int m_road  = 0;
    int m_el    = 0;
    int m_next  = 0;
    bit m_pend  = 1'b0;
    bit m_after_walk = 1'b0;

    intersection_ctrl #(
        .GREEN_MIN (GREEN_MIN),
        .GREEN_MAX (GREEN_MAX),
        .YELLOW_T  (YELLOW_T),
        .ALL_RED_T (ALL_RED_T),
        .WALK_T    (WALK_T)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_ns   (req_ns),
        .req_ew   (req_ew),
        .ped_req  (ped_req),
        .light_ns (light_ns),
        .light_ew (light_ew),
        .walk     (walk)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] head(input int road);
        if (m_phase == P_GREEN && m_road == road) return 3'b001;
        if (m_phase == P_YELLOW && m_road == road) return 3'b010;
        return 3'b100;
    endfunction

    task automatic model_edge();
        int  np;
        int  nr;
        bit  comp;
        if (rst) begin
            m_phase = P_RED; m_road = 0; m_el = 0;
            m_pend = 1'b0; m_next = 0; m_after_walk = 1'b0;
        end else begin
            np = m_phase;
            nr = m_road;
            case (m_phase)
                P_RED: if (m_el + 1 >= ALL_RED_T) begin
                    if (m_pend && !m_after_walk) np = P_WALK;
                    else begin np = P_GREEN; nr = m_next; end
                    m_after_walk = 1'b0;
                end
                P_GREEN: begin
                    comp = ((m_road == 0) ? req_ew : req_ns) || m_pend;
                    if (comp && m_el + 1 >= GREEN_MIN) np = P_YELLOW;
                end
                P_YELLOW: if (m_el + 1 >= YELLOW_T) begin
                    np = P_RED;
                    m_next = 1 - m_next;
                end
                default: if (m_el + 1 >= WALK_T) begin
                    np = P_RED;
                    m_after_walk = 1'b1;
                end
            endcase
`ifdef INTERSECTION_PED_WALK_EN
            if (np == P_WALK && m_phase != P_WALK) m_pend = 1'b0;
            else if (ped_req) m_pend = 1'b1;
`endif
            m_el = (np != m_phase) ? 0 : m_el + 1;
            m_phase = np;
            m_road = nr;
        end
    endtask

    task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic expect_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic ns, input logic ew, input logic p);
        rst = r; req_ns = ns; req_ew = ew; ped_req = p;
        @(posedge clk);
        model_edge();
        #1;
        check3("light_ns", light_ns, head(0));
        check3("light_ew", light_ew, head(1));
        check3("walk", {2'b00, walk}, {2'b00, (m_phase == P_WALK)});
        check3("no_overlap", {2'b00, (light_ns != 3'b100 && light_ew != 3'b100)}, 3'b000);
    endtask

    initial begin
        int ns_g;
        int ew_g;
        int wk;
        int guard;

        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check3("reset_ns_red", light_ns, 3'b100);
        check3("reset_ew_red", light_ew, 3'b100);

        // Rest in NS green with no demand
        ns_g = 0; ew_g = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            if (light_ns == 3'b001) ns_g++;
            if (light_ew != 3'b100) ew_g++;
        end
        expect_int("rest_ns_green_cycles", ns_g, 20);
        expect_int("rest_ew_not_red_cycles", ew_g, 0);

        // EW demand cuts NS green at minimum
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        ns_g = 0; ew_g = 0;
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            if (light_ns == 3'b001) ns_g++;
            if (light_ew == 3'b001) ew_g++;
        end
        expect_int("ew_demand_ns_green", ns_g, GREEN_MIN);
        expect_int("ew_demand_ew_green", ew_g, 14 - GREEN_MIN - YELLOW_T - ALL_RED_T);

        // Both roads demanding: alternation
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        ns_g = 0; ew_g = 0;
        for (int i = 0; i < 28; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0);
            if (light_ns == 3'b001) ns_g++;
            if (light_ew == 3'b001) ew_g++;
        end
        expect_int("alt_ns_green", ns_g, 2 * GREEN_MIN);
        expect_int("alt_ew_green", ew_g, 2 * GREEN_MIN);

        // Pedestrian pulse during NS green
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        wk = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            if (walk) wk++;
        end
        expect_int("ped_walk_cycles", wk, EXP_WALKS);

        // Reset during EW yellow with a pending pedestrian request
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        guard = 0;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        while (!(m_phase == P_GREEN && m_road == 1) && guard < 30) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        guard = 0;
        while (!(m_phase == P_YELLOW && m_road == 1) && guard < 30) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        check3("ew_yellow_before_rst", light_ew, 3'b010);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check3("mid_yellow_rst_ns", light_ns, 3'b100);
        check3("mid_yellow_rst_ew", light_ew, 3'b100);
        wk = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            if (walk) wk++;
        end
        expect_int("pending_lost_after_rst", wk, 0);

        // Randomized traffic, buttons and occasional resets
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/intersection_ctrl.md
INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 Parameter GREEN_MIN, default 4: minimum green duration in clk cycles.
REQ-002 Parameter GREEN_MAX, default 8: maximum green duration under competing demand, in clk cycles.
REQ-003 Parameter YELLOW_T, default 2: yellow duration in clk cycles.
REQ-004 Parameter ALL_RED_T, default 1: all-red clearance duration in clk cycles.
REQ-005 Parameter WALK_T, default 3: pedestrian walk duration in clk cycles.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 req_ns  input  1  vehicle demand on north-south road, level.
REQ-009 req_ew  input  1  vehicle demand on east-west road, level.
REQ-010 ped_req  input  1  pedestrian button, single-cycle or level.
REQ-011 light_ns  output  3  NS signal head {R,Y,G} one-hot: 100 red, 010 yellow, 001 green.
REQ-012 light_ew  output  3  EW signal head, same encoding.
REQ-013 walk  output  1  pedestrian walk indication.

Function
REQ-014 The block SHALL be a Moore FSM; outputs decode only the registered state. States: ALL_RED, NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, PED_WALK.
REQ-015 A cycle counter SHALL reset to 0 on every state entry and increment each cycle in that state, saturating at GREEN_MAX-1.
REQ-016 ALL_RED SHALL last ALL_RED_T cycles and then enter PED_WALK if ped_pending, else the green of next_road.
REQ-017 In a green state, "competing demand" is the other road's req or ped_pending.
REQ-018 The block SHALL leave green for the matching yellow when counter >= GREEN_MIN-1 and competing demand is high; it SHALL leave no later than counter == GREEN_MAX-1 while competing demand is high.
REQ-019 Without competing demand the block SHALL rest in green indefinitely.
REQ-020 Each yellow SHALL last YELLOW_T cycles and then enter ALL_RED.
REQ-021 next_road SHALL toggle on every yellow exit; after PED_WALK, the block SHALL go through ALL_RED to the green of next_road.
REQ-022 PED_WALK SHALL last WALK_T cycles with both heads red and walk=1; walk=0 in every other state.
REQ-023 ped_pending SHALL set on any cycle with ped_req=1 and clear on entry to PED_WALK; a ped_req during PED_WALK SHALL be held for the next cycle.
REQ-024 No state SHALL ever drive green or yellow on both heads simultaneously; the path between any two greens SHALL pass through yellow and ALL_RED.

Reset
REQ-025 With rst=1 on a rising edge, the block SHALL enter ALL_RED with counter=0, ped_pending=0, next_road=NS; light_ns=light_ew=100 and walk=0 from the following cycle.
REQ-026 Reset mid-phase (including mid-yellow or mid-walk) SHALL take priority over every transition and discard pending requests.

Configuration
REQ-027 Macro INTERSECTION_PED_WALK_EN: when defined, PED_WALK, ped_pending and walk behave per REQ-022/023.
REQ-028 When undefined, ped_req SHALL be ignored, PED_WALK SHALL be unreachable, and walk SHALL be tied to 0.

Structure
REQ-029 Package intersection_pkg SHALL hold the state encoding and the light encodings LIGHT_RED, LIGHT_YELLOW, LIGHT_GREEN.
REQ-030 Sub-module phase_timer (counter with clear, saturation and a compare flag) SHALL be instantiated once.

Verification (defaults: GREEN_MIN=4, GREEN_MAX=8, YELLOW_T=2, ALL_RED_T=1, WALK_T=3)
REQ-031 Reset release with no requests -> 1 cycle ALL_RED, then NS green held for 20 cycles, EW red throughout.
REQ-032 req_ew raised at cycle 1 of NS_GREEN -> NS green exactly 4 cycles, yellow 2, all-red 1, then EW green.
REQ-033 req_ns and req_ew both held high -> alternating greens of 4 cycles each, separated by 2 yellow + 1 all-red, no overlap.
REQ-034 ped_req single-cycle pulse during NS_GREEN -> after yellow and all-red, walk=1 for 3 cycles with both heads red, then all-red, then EW green.
REQ-035 rst asserted during EW_YELLOW -> next cycle both heads 100 and walk=0; pending ped request lost.
REQ-036 Build without INTERSECTION_PED_WALK_EN and pulse ped_req -> walk stays 0 and the phase sequence is unchanged.
